// File: rtl/rf_sweep_if.sv
// rf_sweep_if: bus bundle for the rf_sweep register file.
//   master side (datapath) drives the write port, the two read addresses and
//   the clear request; slave side (register file) returns read data and busy.
//   clr       clear-sweep request
//   we/wa/wd  write enable, address, data
//   wbe       per-byte write enables, bit i covers wd[8i+7:8i]
//   ra1/ra2   read addresses
//   rd1/rd2   combinational read data
//   busy      high while the clear sweep runs
interface rf_sweep_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  clr;
  logic                  we;
  logic [ADDR_W-1:0]     wa;
  logic [DATA_W-1:0]     wd;
  logic [DATA_W/8-1:0]   wbe;
  logic [ADDR_W-1:0]     ra1;
  logic [ADDR_W-1:0]     ra2;
  logic [DATA_W-1:0]     rd1;
  logic [DATA_W-1:0]     rd2;
  logic                  busy;

  modport master (
    output clr, we, wa, wd, wbe, ra1, ra2,
    input  rd1, rd2, busy
  );

  modport slave (
    input  clr, we, wa, wd, wbe, ra1, ra2,
    output rd1, rd2, busy
  );
endinterface

// File: rtl/rf_sweep.sv
// rf_sweep: parametrised 2-read / 1-write register file with per-byte write
// enables, optional write-to-read bypass, optional hard-wired zero entry and
// a sequenced clear engine that zeroes one entry per cycle.
//   clk   clock, all state changes on the rising edge
//   rstn  synchronous active-low reset; restarts the clear sweep at entry 0
//   bus   rf_sweep_if slave modport (clr, we, wa, wd, wbe, ra1, ra2 in;
//         rd1, rd2, busy out)
// Parameters: DATA_W (multiple of 8), ADDR_W (DEPTH = 2**ADDR_W),
//             ZERO_R0 (entry 0 reads 0, ignores writes),
//             BYPASS (same-cycle committed write forwarded to read ports).
module rf_sweep #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  rf_sweep_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptr_nxt;

  logic [DATA_W-1:0]   rf [DEPTH];

  logic                busy;
  logic                sweep_wr;
  logic                wr_commit;
  logic [DATA_W-1:0]   wr_old;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rd1_val;
  logic [DATA_W-1:0]   rd2_val;

  // Byte-lane merge: lanes with be set take the new data, others keep old.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Read-port resolution in priority order: sweep forces zero, then the
  // hard-wired zero entry, then a same-cycle committed write, then storage.
  function automatic logic [DATA_W-1:0] read_resolve(
    input logic              busy_i,
    input logic              commit_i,
    input logic [ADDR_W-1:0] wa_i,
    input logic [ADDR_W-1:0] ra_i,
    input logic [DATA_W-1:0] merged_i,
    input logic [DATA_W-1:0] stored_i
  );
    logic [DATA_W-1:0] res;
    if (busy_i)                                res = '0;
    else if (ZERO_R0 && (ra_i == '0))          res = '0;
    else if (BYPASS && commit_i && (wa_i == ra_i)) res = merged_i;
    else                                       res = stored_i;
    return res;
  endfunction

  assign busy = (state == ST_CLEAR);

  // The sweep only writes while out of reset; rstn held low leaves the array
  // untouched.
  assign sweep_wr = busy && rstn;

  // Writes are dropped during the sweep and in the cycle a clear is accepted;
  // entry 0 is never written when it is hard-wired to zero.
  assign wr_commit = bus.we && !busy && !bus.clr &&
                     !(ZERO_R0 && (bus.wa == '0));

  assign wr_old    = rf[bus.wa];
  assign wr_merged = byte_merge(wr_old, bus.wd, bus.wbe);

  // Control state: only the FSM and sweep pointer are reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_CLEAR: begin
        // ptr wraps to 0 naturally on the final entry.
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == LAST) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.clr) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Storage carries no reset; the sweep is the only way entries are zeroed.
  // sweep_wr and wr_commit are mutually exclusive (commit requires !busy).
  always_ff @(posedge clk) begin
    if (sweep_wr) begin
      rf[ptr] <= '0;
    end else if (wr_commit) begin
      rf[bus.wa] <= wr_merged;
    end
  end

  always_comb begin
    rd1_val = read_resolve(busy, wr_commit, bus.wa, bus.ra1, wr_merged, rf[bus.ra1]);
    rd2_val = read_resolve(busy, wr_commit, bus.wa, bus.ra2, wr_merged, rf[bus.ra2]);
  end

  assign bus.rd1  = rd1_val;
  assign bus.rd2  = rd2_val;
  assign bus.busy = busy;

endmodule
